// File: rtl/lcd_bus_capture.sv
// lcd_bus_capture: snoops CPU bus writes to the three LCD windows, turns each
// accepted write into a linear display word index plus data, and queues the
// result in a small first-word-fall-through FIFO. The display controller
// drains the FIFO over a valid/ready handshake.
module lcd_bus_capture #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic [19:0]              addr_in,
    input  logic [15:0]              data_in,
    input  logic                     we_n_in,
    output logic                     lcd_valid_o,
    input  logic                     lcd_ready_in,
    output logic [9:0]               lcd_addr_o,
    output logic [15:0]              lcd_data_o,
    output logic [$clog2(DEPTH):0]   fifo_level_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Bus edge detection
    logic        we_d;
    logic [19:0] addr_d;
    logic        wr_event;

    // Window decode
    logic        hit;
    logic [9:0]  base;
    logic [9:0]  index;

    // Stage 1 capture
    logic        s1_valid;
    logic [9:0]  s1_index;
    logic [15:0] s1_data;

    // FIFO storage and control
    logic [25:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [LVL_W-1:0] level_after_pop;
    logic [PTR_W-1:0] head_ptr;

    // Registered copies of the strobe and address for edge/change detection
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            we_d   <= 1'b1;
            addr_d <= '0;
        end else begin
            we_d   <= we_n_in;
            addr_d <= addr_in;
        end
    end

    // A held strobe yields one event per distinct address
    assign wr_event = !we_n_in && (we_d || (addr_in != addr_d));

    // Decode the three 0x60-nibble windows into a region base and word offset
    always_comb begin
        hit  = 1'b0;
        base = '0;
        case (addr_in[19:8])
            12'h2E1: begin hit = (addr_in[7:0] < 8'h60); base = 10'd0;  end
            12'h2E2: begin hit = (addr_in[7:0] < 8'h60); base = 10'd24; end
            12'h2E3: begin hit = (addr_in[7:0] < 8'h60); base = 10'd48; end
            default: begin hit = 1'b0; base = '0; end
        endcase
        index = base + {4'b0000, addr_in[7:2]};
    end

    // Stage 1: capture index and data of an in-window write event
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= wr_event && hit;
            if (wr_event && hit) begin
                s1_index <= index;
                s1_data  <= data_in;
            end
        end
    end

    assign pop  = lcd_valid_o && lcd_ready_in;
    assign full = (level == FULL_LVL);
    assign push = s1_valid && (!full || pop);
    assign drop = s1_valid && full && !pop;

    // The head register only sees entries already stored before this edge,
    // which gives the extra clock of latency and keeps the outputs free of
    // any path from the bus. After a pop it advances to the next stored slot.
    assign level_after_pop = level - LVL_W'(pop);
    assign head_ptr        = rptr + PTR_W'(pop);

    // Stage 2: FIFO RAM write
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wptr] <= {s1_index, s1_data};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Registered head of queue; address/data hold their last value when empty
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            lcd_valid_o <= 1'b0;
            lcd_addr_o  <= '0;
            lcd_data_o  <= '0;
        end else begin
            lcd_valid_o <= (level_after_pop != '0);
            if (level_after_pop != '0) begin
                {lcd_addr_o, lcd_data_o} <= mem[head_ptr];
            end
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end
        end
    end

    assign fifo_level_o = level;

endmodule
